bimodal_bp: RTL and testbench
=============================

BIMODAL_BP -- requirements
Module: bimodal_bp

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of BTB/counter entries (power of 2, 4..256).
REQ-002 SHALL have parameter MODE, default BP_BIMODAL, selects BP_ALWAYS_TAKEN or BP_BIMODAL prediction.
REQ-003 SHALL have parameter CTR_INIT, default 2'b10, counter value loaded on reset and on allocation.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: predictor_en in 1 enable; pc_IF in 32 fetch PC; instr_IF in 32 fetched instruction.
REQ-006 SHALL have ports: pc_EX in 32 EX PC; instr_EX in 32 EX instruction; pc_sel_EX in 1 branch resolved taken; aludata_EX in 32 resolved target.
REQ-007 SHALL have ports: pred_taken_EX in 1 and pred_target_EX in 32, the IF prediction carried down the pipeline with the EX instruction.
REQ-008 SHALL have ports: hit out 1 redirect valid; pred_taken_IF out 1 IF prediction; npc out 32 redirect PC; flush_br out 1 mispredict flush.
REQ-009 SHALL have ports: br_cnt out 32 resolved branches; mispred_cnt out 32 mispredictions.

Function
REQ-010 SHALL decode a branch as opcode [6:0] == 7'b1100011 in IF and in EX.
REQ-011 SHALL index with pc[IDXW+1:2] and tag with pc[31:IDXW+2], IDXW = log2(ENTRIES).
REQ-012 SHALL report an IF lookup hit when the entry is valid, its tag matches, and instr_IF is a branch.
REQ-013 SHALL drive pred_taken_IF = lookup hit AND (MODE==BP_ALWAYS_TAKEN OR counter[1]), combinationally.
REQ-014 SHALL drive hit=1 and npc = stored target when pred_taken_IF=1 and no EX redirect is active.
REQ-015 SHALL declare a mispredict for an EX branch when pred_taken_EX != pc_sel_EX, or when both are 1 and pred_target_EX != aludata_EX.
REQ-016 SHALL, on mispredict, assert flush_br=1 and hit=1 and drive npc = aludata_EX if pc_sel_EX else pc_EX+4, in the same cycle.
REQ-017 SHALL give the EX redirect priority over the IF prediction when both occur in one cycle.
REQ-018 SHALL drive hit=0, flush_br=0, npc=pc_IF+4 when no redirect and no predicted-taken branch is present; all outputs are free of latches.
REQ-019 SHALL, at the clock edge after a taken EX branch, write valid=1, tag and target=aludata_EX for pc_EX's index.
REQ-020 SHALL, on that write, set counter to CTR_INIT if the entry missed (allocation), else saturating-increment it (max 2'b11).
REQ-021 SHALL, at the clock edge after a not-taken EX branch that hits, saturating-decrement its counter (min 2'b00) and leave the target unchanged.
REQ-022 SHALL leave tables unchanged for a not-taken EX branch that misses.
REQ-023 SHALL return the pre-update value to an IF lookup of the same index updated in the same cycle.
REQ-024 SHALL increment br_cnt per EX branch and mispred_cnt per mispredict, wrapping modulo 2^32.
REQ-025 SHALL, while predictor_en=0, force pred_taken_IF=0, hit=0, flush_br=0, npc=pc_IF+4, and freeze tables and counters.

Reset
REQ-026 SHALL, on rst_ni low (asynchronous), clear all valid bits, set all counters to CTR_INIT, and clear br_cnt and mispred_cnt.
REQ-027 SHALL drive no redirect while in reset, and SHALL lose any update pending at the clock edge coinciding with reset assertion.

Structure
REQ-028 SHALL place opcode constants, the 2-bit counter typedef, the bp_mode_e enum (BP_ALWAYS_TAKEN, BP_BIMODAL) and the saturate helpers in package bp_pkg.
REQ-029 SHALL implement valid/tag/target/counter storage in sub-module bp_btb, with one combinational read port and one synchronous write port.

Verification
REQ-030 SHALL cover cold miss: reset, branch at pc 0x100 taken to 0x200 with pred_taken_EX=0 -> flush_br=1, npc=0x200; next fetch of 0x100 -> pred_taken_IF=1, npc=0x200.
REQ-031 SHALL cover hysteresis: branch at 0x100 taken once, then not-taken once (counter 10->01) -> next IF predicts not taken; MODE=BP_ALWAYS_TAKEN still predicts taken.
REQ-032 SHALL cover target change: entry 0x100->0x200, EX resolves taken to 0x300 with pred_target_EX=0x200 -> flush_br=1, npc=0x300, entry target becomes 0x300.
REQ-033 SHALL cover aliasing: with ENTRIES=16, pc 0x100 and 0x140 share index 0 -> 0x140 misses on tag; a taken 0x140 replaces the entry.
REQ-034 SHALL cover the simultaneous case: IF predicted-taken hit and EX mispredict in one cycle -> npc equals the EX redirect; an IF read of the index being written returns the old entry.
REQ-035 SHALL cover saturation, disable and reset: 5 taken outcomes leave counter=11; predictor_en=0 gives hit=0 with frozen counters; rst_ni low mid-run clears all entries and statistics.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the bimodal branch predictor slice:
//   - RISC-V conditional-branch opcode and a decode helper
//   - 2-bit saturating counter type with increment/decrement helpers
//   - prediction mode selector (bp_mode_e)
//   - BTB write-port operation selector (bp_upd_e)
// No ports; imported by bp_btb and bimodal_bp.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_MAX = 2'b11;
    localparam ctr_t CTR_MIN = 2'b00;

    typedef enum logic {
        BP_ALWAYS_TAKEN = 1'b0,
        BP_BIMODAL      = 1'b1
    } bp_mode_e;

    // A taken outcome (re)writes the whole entry; a not-taken outcome only
    // nudges the counter of an entry that already matches.
    typedef enum logic {
        UPD_TAKEN     = 1'b0,
        UPD_NOT_TAKEN = 1'b1
    } bp_upd_e;

    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[6:0] == OPC_BRANCH);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_MAX) ? CTR_MAX : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_MIN) ? CTR_MIN : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// ---------------------------------------------------------------------------
// bp_btb
// Branch target buffer storage: per-entry valid bit, tag, target and 2-bit
// counter. One combinational read port (used by the IF lookup) and one
// synchronous write port (driven by the resolved EX branch).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rd_idx               read index
//   rd_valid/rd_tag/rd_target/rd_ctr   entry contents at rd_idx
//   wr_en                perform an update at the next clock edge
//   wr_op                UPD_TAKEN or UPD_NOT_TAKEN
//   wr_idx/wr_tag        entry addressed by the EX branch
//   wr_target            resolved target (used on UPD_TAKEN)
// ---------------------------------------------------------------------------
module bp_btb
    import bp_pkg::*;
#(
    parameter int   ENTRIES  = 16,
    parameter ctr_t CTR_INIT = 2'b10,
    localparam int  IDXW     = $clog2(ENTRIES),
    localparam int  TAGW     = 30 - IDXW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDXW-1:0]   rd_idx,
    output logic              rd_valid,
    output logic [TAGW-1:0]   rd_tag,
    output logic [31:0]       rd_target,
    output ctr_t              rd_ctr,
    input  logic              wr_en,
    input  bp_upd_e           wr_op,
    input  logic [IDXW-1:0]   wr_idx,
    input  logic [TAGW-1:0]   wr_tag,
    input  logic [31:0]       wr_target
);

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    ctr_t            ctr_q    [ENTRIES];

    logic            wr_hit;

    // Reads see the registered contents, so a lookup of the entry being
    // written this cycle returns the value from before the update.
    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Entry update. A taken branch that misses allocates with a fresh
    // counter; one that hits strengthens the existing counter. A not-taken
    // branch only weakens a matching entry and never allocates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (wr_en) begin
            case (wr_op)
                UPD_TAKEN: begin
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= wr_tag;
                    target_q[wr_idx] <= wr_target;
                    ctr_q[wr_idx]    <= wr_hit ? sat_inc(ctr_q[wr_idx]) : CTR_INIT;
                end
                UPD_NOT_TAKEN: begin
                    if (wr_hit) begin
                        ctr_q[wr_idx] <= sat_dec(ctr_q[wr_idx]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bimodal_bp.sv
// ---------------------------------------------------------------------------
// bimodal_bp
// Bimodal branch predictor with a direct-mapped BTB. The IF stage looks up
// the fetch PC and, if a known branch is predicted taken, redirects fetch to
// the stored target. The EX stage resolves the branch, flushes and redirects
// on a mispredict, and trains the BTB at the following clock edge.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   predictor_en           0 = no predictions, no training, counters frozen
//   pc_IF, instr_IF        fetch PC and fetched instruction
//   pc_EX, instr_EX        PC and instruction in EX
//   pc_sel_EX              EX branch resolved taken
//   aludata_EX             EX resolved target
//   pred_taken_EX          prediction that was made for the EX instruction
//   pred_target_EX         target that was predicted for the EX instruction
//   hit                    redirect valid (EX correction or IF prediction)
//   pred_taken_IF          IF prediction for the current fetch
//   npc                    next fetch PC
//   flush_br               mispredict flush
//   br_cnt, mispred_cnt    resolved branch / mispredict statistics
// ---------------------------------------------------------------------------
module bimodal_bp
    import bp_pkg::*;
#(
    parameter int       ENTRIES  = 16,
    parameter bp_mode_e MODE     = BP_BIMODAL,
    parameter ctr_t     CTR_INIT = 2'b10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        predictor_en,
    input  logic [31:0] pc_IF,
    input  logic [31:0] instr_IF,
    input  logic [31:0] pc_EX,
    input  logic [31:0] instr_EX,
    input  logic        pc_sel_EX,
    input  logic [31:0] aludata_EX,
    input  logic        pred_taken_EX,
    input  logic [31:0] pred_target_EX,
    output logic        hit,
    output logic        pred_taken_IF,
    output logic [31:0] npc,
    output logic        flush_br,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic              active;
    logic [IDXW-1:0]   if_idx;
    logic [TAGW-1:0]   if_tag;
    logic [IDXW-1:0]   ex_idx;
    logic [TAGW-1:0]   ex_tag;
    logic              if_is_br;
    logic              ex_is_br;
    logic              rd_valid;
    logic [TAGW-1:0]   rd_tag;
    logic [31:0]       rd_target;
    ctr_t              rd_ctr;
    logic              lookup_hit;
    logic              mispredict;
    logic              wr_en;
    bp_upd_e           wr_op;
    logic              unused_instr_bits;

    // Only the opcode field of each instruction matters to the predictor.
    assign unused_instr_bits = ^{instr_IF[31:7], instr_EX[31:7]};

    // Gating with rst_ni keeps every redirect quiet while reset is held,
    // even if the EX inputs look like a mispredict.
    assign active = predictor_en && rst_ni;

    assign if_idx   = pc_IF[IDXW+1:2];
    assign if_tag   = pc_IF[31:IDXW+2];
    assign ex_idx   = pc_EX[IDXW+1:2];
    assign ex_tag   = pc_EX[31:IDXW+2];
    assign if_is_br = is_branch(instr_IF);
    assign ex_is_br = is_branch(instr_EX);

    bp_btb #(
        .ENTRIES  (ENTRIES),
        .CTR_INIT (CTR_INIT)
    ) u_btb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_idx    (if_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctr    (rd_ctr),
        .wr_en     (wr_en),
        .wr_op     (wr_op),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_target (aludata_EX)
    );

    assign lookup_hit = rd_valid && (rd_tag == if_tag) && if_is_br;

    // A taken prediction with the wrong target is as bad as a wrong
    // direction: fetch went down the wrong path either way.
    assign mispredict = active && ex_is_br &&
                        ((pred_taken_EX != pc_sel_EX) ||
                         (pc_sel_EX && pred_taken_EX && (pred_target_EX != aludata_EX)));

    assign wr_en = active && ex_is_br;
    assign wr_op = pc_sel_EX ? UPD_TAKEN : UPD_NOT_TAKEN;

    // Redirect selection: an EX correction always beats an IF prediction,
    // because the instruction being fetched is on the wrong path anyway.
    always_comb begin
        pred_taken_IF = 1'b0;
        hit           = 1'b0;
        flush_br      = 1'b0;
        npc           = pc_IF + 32'd4;

        pred_taken_IF = active && lookup_hit &&
                        ((MODE == BP_ALWAYS_TAKEN) || rd_ctr[1]);

        if (mispredict) begin
            hit      = 1'b1;
            flush_br = 1'b1;
            npc      = pc_sel_EX ? aludata_EX : (pc_EX + 32'd4);
        end else if (pred_taken_IF) begin
            hit = 1'b1;
            npc = rd_target;
        end
    end

    // Statistics freeze together with the tables when the predictor is off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (predictor_en && ex_is_br) begin
            br_cnt <= br_cnt + 32'd1;
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bimodal_bp.sv
// ---------------------------------------------------------------------------
// tb_bimodal_bp
// Self-checking bench for bimodal_bp. Two instances share all inputs: one in
// bimodal mode and one in always-taken mode. A behavioural model keeps one
// record per BTB slot (branch PC, target, integer confidence 0..3) and
// predicts every output from those records.
// ---------------------------------------------------------------------------
module tb_bimodal_bp;
    import bp_pkg::*;

    localparam logic [31:0] BR  = 32'h0000_0063;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        predictor_en;
    logic [31:0] pc_IF, instr_IF, pc_EX, instr_EX, aludata_EX, pred_target_EX;
    logic        pc_sel_EX, pred_taken_EX;

    logic        hit, pred_taken_IF, flush_br;
    logic [31:0] npc, br_cnt, mispred_cnt;
    logic        at_hit, at_pred_taken_IF, at_flush_br;
    logic [31:0] at_npc, at_br_cnt, at_mispred_cnt;

    int          nVectors = 0;
    int          nMiscompares = 0;

    // Model state: one record per slot.
    bit          m_valid  [16];
    logic [31:0] m_pc     [16];
    logic [31:0] m_target [16];
    int          m_conf   [16];
    logic [31:0] exp_br;
    logic [31:0] exp_mis;

    always #5 clk_i = ~clk_i;

    bimodal_bp #(.ENTRIES(16), .MODE(BP_BIMODAL), .CTR_INIT(2'b10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .predictor_en(predictor_en),
        .pc_IF(pc_IF), .instr_IF(instr_IF), .pc_EX(pc_EX), .instr_EX(instr_EX),
        .pc_sel_EX(pc_sel_EX), .aludata_EX(aludata_EX),
        .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
        .hit(hit), .pred_taken_IF(pred_taken_IF), .npc(npc), .flush_br(flush_br),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    bimodal_bp #(.ENTRIES(16), .MODE(BP_ALWAYS_TAKEN), .CTR_INIT(2'b10)) dut_at (
        .clk_i(clk_i), .rst_ni(rst_ni), .predictor_en(predictor_en),
        .pc_IF(pc_IF), .instr_IF(instr_IF), .pc_EX(pc_EX), .instr_EX(instr_EX),
        .pc_sel_EX(pc_sel_EX), .aludata_EX(aludata_EX),
        .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
        .hit(at_hit), .pred_taken_IF(at_pred_taken_IF), .npc(at_npc), .flush_br(at_flush_br),
        .br_cnt(at_br_cnt), .mispred_cnt(at_mispred_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slotOf(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic bit modelKnows(input logic [31:0] pc);
        int s;
        s = slotOf(pc);
        return m_valid[s] && (m_pc[s][31:6] == pc[31:6]);
    endfunction

    function automatic bit isBr(input logic [31:0] instr);
        return instr[6:0] == 7'b1100011;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_pc[i]     = '0;
            m_target[i] = '0;
            m_conf[i]   = 2;
        end
        exp_br  = '0;
        exp_mis = '0;
    endtask

    // Drives one cycle of inputs starting just after a rising edge, checks
    // the combinational outputs at the falling edge, then advances the model
    // across the rising edge and checks the statistics.
    task automatic applyStimulus(
        input logic        en,
        input logic [31:0] pcif, input logic [31:0] instrif,
        input logic [31:0] pcex, input logic [31:0] instrex,
        input logic        sel,  input logic [31:0] alu,
        input logic        ptk,  input logic [31:0] ptgt
    );
        bit          known_if, known_ex, ep, ep_at, mis;
        logic [31:0] redirect, enpc, enpc_at;
        int          s;

        predictor_en   = en;
        pc_IF          = pcif;
        instr_IF       = instrif;
        pc_EX          = pcex;
        instr_EX       = instrex;
        pc_sel_EX      = sel;
        aludata_EX     = alu;
        pred_taken_EX  = ptk;
        pred_target_EX = ptgt;
        #4;

        known_if = isBr(instrif) && modelKnows(pcif);
        ep       = en && known_if && (m_conf[slotOf(pcif)] >= 2);
        ep_at    = en && known_if;
        mis      = en && isBr(instrex) &&
                   ((ptk != sel) || (sel && ptk && (ptgt != alu)));
        redirect = sel ? alu : pcex + 32'd4;
        enpc     = mis ? redirect : (ep    ? m_target[slotOf(pcif)] : pcif + 32'd4);
        enpc_at  = mis ? redirect : (ep_at ? m_target[slotOf(pcif)] : pcif + 32'd4);

        checkOutput("pred_taken_IF", {31'b0, pred_taken_IF}, {31'b0, ep});
        checkOutput("hit",           {31'b0, hit},           {31'b0, mis || ep});
        checkOutput("flush_br",      {31'b0, flush_br},      {31'b0, mis});
        checkOutput("npc",           npc,                    enpc);
        checkOutput("at_pred_taken", {31'b0, at_pred_taken_IF}, {31'b0, ep_at});
        checkOutput("at_hit",        {31'b0, at_hit},        {31'b0, mis || ep_at});
        checkOutput("at_npc",        at_npc,                 enpc_at);

        @(posedge clk_i);
        if (en && isBr(instrex)) begin
            exp_br = exp_br + 32'd1;
            if (mis) exp_mis = exp_mis + 32'd1;
            s        = slotOf(pcex);
            known_ex = modelKnows(pcex);
            if (sel) begin
                m_conf[s]   = known_ex ? ((m_conf[s] < 3) ? m_conf[s] + 1 : 3) : 2;
                m_valid[s]  = 1'b1;
                m_pc[s]     = pcex;
                m_target[s] = alu;
            end else if (known_ex) begin
                m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
            end
        end
        #1;
        checkOutput("br_cnt",         br_cnt,         exp_br);
        checkOutput("mispred_cnt",    mispred_cnt,    exp_mis);
        checkOutput("at_mispred_cnt", at_mispred_cnt, exp_mis);
    endtask

    // Shorthands for IF-only and EX-only cycles.
    task automatic fetch(input logic [31:0] pc);
        applyStimulus(1'b1, pc, BR, 32'h0, NOP, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic sel, input logic [31:0] alu,
                           input logic ptk, input logic [31:0] ptgt);
        applyStimulus(1'b1, 32'h0, NOP, pc, BR, sel, alu, ptk, ptgt);
    endtask

    task automatic applyReset();
        rst_ni = 1'b0; predictor_en = 1'b1;
        pc_IF = 32'h0; instr_IF = NOP; pc_EX = 32'h0; instr_EX = NOP;
        pc_sel_EX = 1'b0; aludata_EX = 32'h0; pred_taken_EX = 1'b0; pred_target_EX = 32'h0;
        modelReset();
        #3;
        checkOutput("rst_hit",     {31'b0, hit},      32'h0);
        checkOutput("rst_flush",   {31'b0, flush_br}, 32'h0);
        checkOutput("rst_npc",     npc,               32'h4);
        checkOutput("rst_br_cnt",  br_cnt,            32'h0);
        checkOutput("rst_mis_cnt", mispred_cnt,       32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [31:0] rp_if, rp_ex, ralu, rtgt;
        logic        rptk;

        $display("[TB] bimodal_bp bench start");
        applyReset();

        // Cold miss, then the freshly allocated entry predicts taken.
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        fetch(32'h100);

        // Hysteresis: a not-taken outcome weakens 10 -> 01.
        resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        fetch(32'h100);

        // Target change on a correctly-predicted direction.
        resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        fetch(32'h100);

        // Aliasing: 0x140 shares slot 0 with 0x100 but has a different tag.
        fetch(32'h140);
        resolve(32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
        fetch(32'h100);
        fetch(32'h140);

        // EX redirect wins over a taken IF prediction in the same cycle.
        applyStimulus(1'b1, 32'h140, BR, 32'h140, BR, 1'b1, 32'h600, 1'b0, 32'h0);
        // Same-slot read during a decrement sees the old counter.
        applyStimulus(1'b1, 32'h140, BR, 32'h140, BR, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h140);

        // Saturation: five taken outcomes, then two not-taken steps down.
        for (int i = 0; i < 5; i++) resolve(32'h184, 1'b1, 32'h800, 1'b1, 32'h800);
        resolve(32'h184, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h184);
        resolve(32'h184, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h184);
        resolve(32'h184, 1'b1, 32'h800, 1'b0, 32'h0);

        // Disabled: no predictions, no flush, nothing trained or counted.
        applyStimulus(1'b0, 32'h184, BR, 32'h184, BR, 1'b0, 32'h0, 1'b1, 32'h800);
        applyStimulus(1'b0, 32'h184, BR, 32'h188, BR, 1'b1, 32'h900, 1'b0, 32'h0);
        fetch(32'h184);
        fetch(32'h188);

        // Mid-run asynchronous reset with a mispredict on the EX inputs.
        predictor_en = 1'b1; pc_IF = 32'h184; instr_IF = BR;
        pc_EX = 32'h184; instr_EX = BR; pc_sel_EX = 1'b1; aludata_EX = 32'hA00;
        pred_taken_EX = 1'b0; pred_target_EX = 32'h0;
        rst_ni = 1'b0;
        modelReset();
        #2;
        checkOutput("midrst_hit",    {31'b0, hit},           32'h0);
        checkOutput("midrst_flush",  {31'b0, flush_br},      32'h0);
        checkOutput("midrst_pred",   {31'b0, pred_taken_IF}, 32'h0);
        checkOutput("midrst_npc",    npc,                    32'h188);
        checkOutput("midrst_br_cnt", br_cnt,                 32'h0);
        @(posedge clk_i); #1;
        checkOutput("midrst_mis_cnt", mispred_cnt, 32'h0);
        rst_ni = 1'b1;
        fetch(32'h184);
        fetch(32'h100);

        // Randomised traffic over a few tags and slots to exercise aliasing.
        for (int n = 0; n < 400; n++) begin
            rp_if = ({$urandom_range(0, 2)} << 6) | ({$urandom_range(0, 3)} << 2);
            rp_ex = ({$urandom_range(0, 2)} << 6) | ({$urandom_range(0, 3)} << 2);
            ralu  = 32'h1000 + ({$urandom_range(0, 3)} << 4);
            if ($urandom_range(0, 1) == 0 && modelKnows(rp_ex)) begin
                rptk = (m_conf[slotOf(rp_ex)] >= 2);
                rtgt = m_target[slotOf(rp_ex)];
            end else begin
                rptk = 1'($urandom_range(0, 1));
                rtgt = ($urandom_range(0, 1) == 0) ? ralu : 32'h1000 + ({$urandom_range(0, 3)} << 4);
            end
            applyStimulus(($urandom_range(0, 9) != 0),
                          rp_if, ($urandom_range(0, 3) != 0) ? BR : NOP,
                          rp_ex, ($urandom_range(0, 3) != 0) ? BR : NOP,
                          1'($urandom_range(0, 1)), ralu, rptk, rtgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
